// File: rtl/buzzer_voice_pkg.sv
// Shared definitions for the buzzer voice: FSM state encoding and counter sizing.
package buzzer_voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOUND = 2'd1,
    ST_GAP   = 2'd2
  } voice_state_e;

  // Gap counter width; kept at least 1 bit so a disabled gap still elaborates.
  function automatic int gap_width(input int gap_clks);
    if (gap_clks < 2) begin
      return 1;
    end else begin
      return $clog2(gap_clks + 1);
    end
  endfunction

endpackage

// File: rtl/buzzer_voice_tempo_tick.sv
// Tempo synchronizer and rising-edge detector; emits a one-clock tick three
// clocks after a tempo rising edge. Falling edges produce nothing.
module buzzer_voice_tempo_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tempo_i,
  output logic tick_o
);

  logic [1:0] sync_q;
  logic       edge_q;
  logic       tick_q;

  // Two-flop synchronizer, edge history and registered tick pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tempo_i};
      edge_q <= sync_q[1];
      tick_q <= sync_q[1] & ~edge_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/buzzer_voice.sv
// One buzzer voice: square-wave tone with glitch-free divisor reloads,
// articulation gaps on tempo ticks and PWM volume.
module buzzer_voice
  import buzzer_voice_pkg::*;
#(
  parameter int DIV_WIDTH = 17,
  parameter int VOL_WIDTH = 1,
  parameter int GAP_CLKS  = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tempo,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [VOL_WIDTH-1:0] volume,
  input  logic                 retrig,
  output logic                 buzzer,
  output logic                 sounding
);

  localparam int             GW       = gap_width(GAP_CLKS);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CLKS - 1);
  localparam bit             GAP_EN   = (GAP_CLKS != 0);

  voice_state_e         state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] act_div_q, act_div_d;
  logic                 square_q, square_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [VOL_WIDTH-1:0] pcnt_q;
  logic                 buzzer_q, buzzer_d;
  logic                 sounding_q;
  logic                 tick_s, toggle_s, div_zero_s, gate_s;

  buzzer_voice_tempo_tick u_tick (
    .clk_i   (clk),
    .rst_i   (reset),
    .tempo_i (tempo),
    .tick_o  (tick_s)
  );

  assign div_zero_s = (div == '0);
  assign toggle_s   = (state_q == ST_SOUND) && (cnt_q == act_div_q - DIV_WIDTH'(1));
  assign gate_s     = (volume == {VOL_WIDTH{1'b1}}) || (pcnt_q < volume);

  // Next-state, tone counter and gap counter logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    square_d  = square_q;
    gcnt_d    = gcnt_q;
    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      square_d = 1'b0;
      gcnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!div_zero_s) begin
            state_d   = ST_SOUND;
            act_div_d = div;
            cnt_d     = '0;
            square_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SOUND: begin
          // A rest is only honoured at a toggle point so the last half-period completes.
          if (toggle_s && div_zero_s) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            square_d = 1'b0;
          end else if (tick_s && ((div != act_div_q) || retrig) && GAP_EN) begin
            state_d  = ST_GAP;
            cnt_d    = '0;
            square_d = 1'b0;
            gcnt_d   = '0;
          end else if (toggle_s) begin
            square_d  = ~square_q;
            cnt_d     = '0;
            act_div_d = div;
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
        ST_GAP: begin
          if (tick_s && retrig) begin
            gcnt_d = '0;
          end else if (gcnt_q == GAP_LAST) begin
            gcnt_d = '0;
            if (!div_zero_s) begin
              state_d   = ST_SOUND;
              act_div_d = div;
              cnt_d     = '0;
              square_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          square_d = 1'b0;
          gcnt_d   = '0;
        end
      endcase
    end
  end

  // Pin is gated by the next state too, so leaving SOUND silences it on that same clock.
  assign buzzer_d = square_q & gate_s & (state_q == ST_SOUND) & (state_d == ST_SOUND);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_div_q  <= '0;
      square_q   <= 1'b0;
      gcnt_q     <= '0;
      pcnt_q     <= '0;
      buzzer_q   <= 1'b0;
      sounding_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      square_q   <= square_d;
      gcnt_q     <= gcnt_d;
      pcnt_q     <= pcnt_q + VOL_WIDTH'(1);
      buzzer_q   <= buzzer_d;
      sounding_q <= (state_d == ST_SOUND);
    end
  end

  assign buzzer   = buzzer_q;
  assign sounding = sounding_q;

endmodule

// File: tb/tb_buzzer_voice.sv
// Self-checking bench for buzzer_voice against a countdown-style behavioural model.
module tb_buzzer_voice;

  localparam int DW   = 17;
  localparam int VW   = 2;
  localparam int GAP  = 16;
  localparam int VMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tempo = 1'b0;
  logic          enable = 1'b0;
  logic          retrig = 1'b0;
  logic [DW-1:0] div = '0;
  logic [VW-1:0] volume = '0;
  logic          buzzer, sounding;

  int tests = 0;
  int fails = 0;

  // Model: mode 0=silent,1=tone,2=gap; rem counts down the current half-period.
  int m_mode, m_rem, m_half, m_level, m_gap_left, m_pwm;
  bit m_buz, m_snd;
  bit tq[$];

  buzzer_voice #(.DIV_WIDTH(DW), .VOL_WIDTH(VW), .GAP_CLKS(GAP)) dut (
    .clk(clk), .reset(reset), .tempo(tempo), .enable(enable), .div(div),
    .volume(volume), .retrig(retrig), .buzzer(buzzer), .sounding(sounding)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_half = 0; m_level = 0; m_gap_left = 0; m_pwm = 0;
    m_buz = 1'b0; m_snd = 1'b0;
    tq = '{1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic sound_load();
    m_half = int'(div); m_rem = int'(div); m_level = 1;
  endtask

  task automatic model_edge();
    int n, nm, old_level;
    bit tick, gate;
    n = tq.size();
    // tempo seen at edge k is acted on at edge k+3
    tick = tq[n-3] && !tq[n-4];
    tq.push_back(tempo);
    if (tq.size() > 8) void'(tq.pop_front());
    gate = (int'(volume) == VMAX) || (m_pwm < int'(volume));
    old_level = m_level;
    nm = m_mode;
    if (!enable) begin
      nm = 0; m_level = 0;
    end else if (m_mode == 0) begin
      if (div != 0) begin nm = 1; sound_load(); end
    end else if (m_mode == 1) begin
      if (m_rem == 1 && div == 0) begin nm = 0; m_level = 0; end
      else if (tick && (int'(div) != m_half || retrig)) begin nm = 2; m_level = 0; m_gap_left = GAP; end
      else if (m_rem == 1) begin m_level = 1 - m_level; m_half = int'(div); m_rem = int'(div); end
      else m_rem = m_rem - 1;
    end else begin
      if (tick && retrig) m_gap_left = GAP;
      else if (m_gap_left == 1) begin
        if (div != 0) begin nm = 1; sound_load(); end
        else nm = 0;
      end else m_gap_left = m_gap_left - 1;
    end
    m_buz = (old_level == 1) && gate && (m_mode == 1) && (nm == 1);
    m_snd = (nm == 1);
    m_mode = nm;
    m_pwm = (m_pwm + 1) % (VMAX + 1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; tempo = 1'b0; retrig = 1'b0; div = '0; volume = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++; if (buzzer !== 1'b0) begin fails++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
      tests++; if (sounding !== 1'b0) begin fails++; $display("FAIL reset_sounding got=%b exp=0", sounding); end
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

  task automatic test_tone();
    int first_high, highs;
    apply_reset();
    div = DW'(4); volume = VW'(VMAX); enable = 1'b1;
    first_high = -1; highs = 0;
    for (int i = 1; i <= 41; i++) begin
      step();
      if (buzzer === 1'b1 && first_high < 0) first_high = i;
      if (i >= 2 && buzzer === 1'b1) highs++;
      tests++; if (buzzer !== m_buz) begin fails++; $display("FAIL tone_buzzer cyc=%0d got=%b exp=%b", i, buzzer, m_buz); end
    end
    tests++; if (first_high != 2) begin fails++; $display("FAIL tone_first_high got=%0d exp=2", first_high); end
    tests++; if (highs != 20) begin fails++; $display("FAIL tone_duty got=%0d exp=20", highs); end
  endtask

  task automatic test_div_change();
    bit trace[40];
    int runs[3], r, k;
    apply_reset();
    div = DW'(4); volume = VW'(VMAX); enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 2) div = DW'(6);
      trace[i] = buzzer;
      tests++; if (buzzer !== m_buz) begin fails++; $display("FAIL divchg_buzzer cyc=%0d got=%b exp=%b", i, buzzer, m_buz); end
    end
    k = 0;
    while (k < 40 && !trace[k]) k++;
    for (int j = 0; j < 3; j++) begin
      r = 0;
      while (k < 40 && trace[k] == ((j % 2) == 0)) begin r++; k++; end
      runs[j] = r;
    end
    tests++; if (runs[0] != 4) begin fails++; $display("FAIL divchg_first_high got=%0d exp=4", runs[0]); end
    tests++; if (runs[1] != 6 || runs[2] != 6) begin fails++; $display("FAIL divchg_period got=%0d/%0d exp=6/6", runs[1], runs[2]); end
  endtask

  task automatic test_gap();
    int quiet, highs;
    apply_reset();
    div = DW'(6); volume = VW'(VMAX); enable = 1'b1;
    repeat (7) step();
    div = DW'(7); tempo = 1'b1;
    quiet = 0; highs = 0;
    for (int i = 1; i <= 28; i++) begin
      step();
      if (i == 10) tempo = 1'b0;
      if (i == 3) begin tests++; if (sounding !== 1'b1) begin fails++; $display("FAIL gap_early got=%b exp=1", sounding); end end
      if (i >= 4 && i <= 19 && sounding === 1'b0) quiet++;
      if (i >= 4 && i <= 20 && buzzer === 1'b1) highs++;
      if (i == 20) begin tests++; if (sounding !== 1'b1) begin fails++; $display("FAIL gap_resume got=%b exp=1", sounding); end end
      if (i >= 21 && i <= 27) begin tests++; if (buzzer !== 1'b1) begin fails++; $display("FAIL gap_m7_high cyc=%0d got=%b exp=1", i, buzzer); end end
      if (i == 28) begin tests++; if (buzzer !== 1'b0) begin fails++; $display("FAIL gap_m7_low got=%b exp=0", buzzer); end end
      tests++; if (buzzer !== m_buz || sounding !== m_snd) begin fails++; $display("FAIL gap_model cyc=%0d got=%b%b exp=%b%b", i, buzzer, sounding, m_buz, m_snd); end
    end
    tests++; if (quiet != 16) begin fails++; $display("FAIL gap_length got=%0d exp=16", quiet); end
    tests++; if (highs != 0) begin fails++; $display("FAIL gap_silent got=%0d exp=0", highs); end
  endtask

  task automatic test_retrig();
    int quiet, loud;
    apply_reset();
    div = DW'(6); volume = VW'(VMAX); enable = 1'b1;
    repeat (5) step();
    tempo = 1'b1; retrig = 1'b1;
    quiet = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 6) retrig = 1'b0;
      if (i == 10) tempo = 1'b0;
      if (i >= 4 && i <= 19 && sounding === 1'b0) quiet++;
      tests++; if (buzzer !== m_buz || sounding !== m_snd) begin fails++; $display("FAIL retrig_model cyc=%0d got=%b%b exp=%b%b", i, buzzer, sounding, m_buz, m_snd); end
    end
    tests++; if (quiet != 16) begin fails++; $display("FAIL retrig_gap got=%0d exp=16", quiet); end
    tempo = 1'b1; loud = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) tempo = 1'b0;
      if (sounding === 1'b1) loud++;
      tests++; if (buzzer !== m_buz) begin fails++; $display("FAIL noretrig_model cyc=%0d got=%b exp=%b", i, buzzer, m_buz); end
    end
    tests++; if (loud != 30) begin fails++; $display("FAIL noretrig_unbroken got=%0d exp=30", loud); end
  endtask

  task automatic test_pwm();
    int highs, adj;
    bit prev;
    apply_reset();
    div = DW'(8); volume = VW'(1); enable = 1'b1;
    repeat (16) step();
    highs = 0; adj = 0; prev = buzzer;
    for (int i = 0; i < 64; i++) begin
      step();
      if (buzzer === 1'b1) highs++;
      if (buzzer === 1'b1 && prev) adj++;
      prev = buzzer;
      tests++; if (buzzer !== m_buz) begin fails++; $display("FAIL pwm_model cyc=%0d got=%b exp=%b", i, buzzer, m_buz); end
    end
    tests++; if (highs != 8) begin fails++; $display("FAIL pwm_quarter got=%0d exp=8", highs); end
    tests++; if (adj != 0) begin fails++; $display("FAIL pwm_adjacent got=%0d exp=0", adj); end
    volume = '0; highs = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (buzzer === 1'b1) highs++;
    end
    tests++; if (highs != 0) begin fails++; $display("FAIL pwm_mute got=%0d exp=0", highs); end
  endtask

  task automatic test_disable_rest();
    apply_reset();
    div = DW'(4); volume = VW'(VMAX); enable = 1'b1;
    repeat (3) step();
    tests++; if (buzzer !== 1'b1) begin fails++; $display("FAIL midnote_high got=%b exp=1", buzzer); end
    #3 reset = 1'b1;
    #1;
    tests++; if (buzzer !== 1'b0 || sounding !== 1'b0) begin fails++; $display("FAIL async_reset got=%b%b exp=00", buzzer, sounding); end
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    div = DW'(6); enable = 1'b1;
    repeat (7) step();
    div = DW'(7); tempo = 1'b1;
    repeat (8) step();
    enable = 1'b0; tempo = 1'b0;
    step();
    tests++; if (buzzer !== 1'b0 || sounding !== 1'b0 || m_snd) begin fails++; $display("FAIL gap_disable got=%b%b exp=00", buzzer, sounding); end
    repeat (6) step();
    div = DW'(5); enable = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 3) div = '0;
      if (j == 5) begin tests++; if (sounding !== 1'b1) begin fails++; $display("FAIL rest_hold got=%b exp=1", sounding); end end
      if (j == 6) begin tests++; if (sounding !== 1'b0) begin fails++; $display("FAIL rest_idle got=%b exp=0", sounding); end end
      tests++; if (buzzer !== m_buz || sounding !== m_snd) begin fails++; $display("FAIL rest_model cyc=%0d got=%b%b exp=%b%b", j, buzzer, sounding, m_buz, m_snd); end
    end
  endtask

  task automatic test_random();
    int tcnt, tlen;
    apply_reset();
    enable = 1'b1; div = DW'(5); volume = VW'(VMAX);
    tcnt = 0; tlen = 30;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) div = DW'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) volume = VW'($urandom_range(0, 3));
      retrig = ($urandom_range(0, 3) == 0);
      tcnt++;
      if (tcnt >= tlen) begin tempo = ~tempo; tcnt = 0; tlen = int'($urandom_range(8, 40)); end
      step();
      tests++; if (buzzer !== m_buz || sounding !== m_snd) begin fails++; $display("FAIL random cyc=%0d got=%b%b exp=%b%b", c, buzzer, sounding, m_buz, m_snd); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tone();
    test_div_change();
    test_gap();
    test_retrig();
    test_pwm();
    test_disable_rest();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
